// File: rtl/posit_op_bridge_if.sv
// Bus bundle between the HPS lightweight bridge, the posit bridge and the posit unit.
// slave = bridge side, master = the surrounding system (Avalon host plus unit).
interface posit_op_bridge_if #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 2
);
    logic [2:0]       avs_address;
    logic             avs_write;
    logic [WIDTH-1:0] avs_writedata;
    logic             avs_read;
    logic [WIDTH-1:0] avs_readdata;
    logic [WIDTH-1:0] num1_export;
    logic [WIDTH-1:0] num2_export;
    logic [OP_W-1:0]  op_export;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] result_export;
    logic             result_valid;

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read,
        input  req_ready, result_export, result_valid,
        output avs_readdata, num1_export, num2_export, op_export, req_valid
    );

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read,
        output req_ready, result_export, result_valid,
        input  avs_readdata, num1_export, num2_export, op_export, req_valid
    );
endinterface

// File: rtl/posit_op_bridge.sv
// Avalon-MM slave that queues posit operations to the arithmetic unit and
// collects results in order, with credit-based result capture.
module posit_op_bridge #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 2,
    parameter int DEPTH = 8
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    posit_op_bridge_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW:0] CREDIT_MAX = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] num1_q, num2_q, rdata_q, rd_next;
    logic [WIDTH-1:0] cmd_a   [DEPTH];
    logic [WIDTH-1:0] cmd_b   [DEPTH];
    logic [OP_W-1:0]  cmd_op  [DEPTH];
    logic [WIDTH-1:0] res_mem [DEPTH];
    logic [PW-1:0]    cmd_wr, cmd_rd, res_wr, res_rd, inflight, res_count;
    logic [PW:0]      credit_sum;
    logic [2:0]       flags;      // {spur, unf, ovf}
    logic [2:0]       flag_set, flag_clr;
    logic [31:0]      done_count, status_word;
    logic             cmd_empty, cmd_full, res_empty;
    logic             issue, capture, spur_hit;
    logic             cmd_wr_req, cmd_push, res_rd_req, res_pop;

    assign cmd_empty  = (cmd_wr == cmd_rd);
    assign cmd_full   = (cmd_wr[AW] != cmd_rd[AW]) && (cmd_wr[AW-1:0] == cmd_rd[AW-1:0]);
    assign res_empty  = (res_wr == res_rd);
    assign res_count  = res_wr - res_rd;
    assign credit_sum = {1'b0, inflight} + {1'b0, res_count};

    // In-flight plus buffered results never exceed DEPTH, so a capture always has room.
    assign bus.req_valid   = !cmd_empty && (credit_sum < CREDIT_MAX);
    assign bus.num1_export = cmd_empty ? '0 : cmd_a[cmd_rd[AW-1:0]];
    assign bus.num2_export = cmd_empty ? '0 : cmd_b[cmd_rd[AW-1:0]];
    assign bus.op_export   = cmd_empty ? '0 : cmd_op[cmd_rd[AW-1:0]];
    assign bus.avs_readdata = rdata_q;

    assign issue      = bus.req_valid && bus.req_ready;
    assign capture    = bus.result_valid && (inflight != '0);
    assign spur_hit   = bus.result_valid && (inflight == '0);
    // A slot freed by this cycle's issue can take a push on a full FIFO.
    assign cmd_wr_req = bus.avs_write && (bus.avs_address == 3'd2);
    assign cmd_push   = cmd_wr_req && (!cmd_full || issue);
    assign res_rd_req = bus.avs_read && (bus.avs_address == 3'd3);
    assign res_pop    = res_rd_req && !res_empty;
    assign flag_set   = {spur_hit, res_rd_req && res_empty, cmd_wr_req && !cmd_push};
    assign flag_clr   = (bus.avs_write && (bus.avs_address == 3'd4)) ? bus.avs_writedata[6:4] : 3'b000;

    always_comb begin
        status_word        = 32'd0;
        status_word[0]     = cmd_full;
        status_word[1]     = cmd_empty;
        status_word[2]     = res_empty;
        status_word[3]     = (inflight != '0);
        status_word[6:4]   = flags;
        status_word[15:8]  = 8'(res_count);
        rd_next = '0;
        case (bus.avs_address)
            3'd0:    rd_next = num1_q;
            3'd1:    rd_next = num2_q;
            3'd3:    rd_next = res_empty ? '0 : res_mem[res_rd[AW-1:0]];
            3'd4:    rd_next = WIDTH'(status_word);
            3'd5:    rd_next = WIDTH'(done_count);
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            num1_q     <= '0;
            num2_q     <= '0;
            rdata_q    <= '0;
            cmd_wr     <= '0;
            cmd_rd     <= '0;
            res_wr     <= '0;
            res_rd     <= '0;
            inflight   <= '0;
            flags      <= '0;
            done_count <= '0;
        end else begin
            if (bus.avs_write && (bus.avs_address == 3'd0)) num1_q <= bus.avs_writedata;
            if (bus.avs_write && (bus.avs_address == 3'd1)) num2_q <= bus.avs_writedata;
            rdata_q <= bus.avs_read ? rd_next : '0;
            if (cmd_push) cmd_wr <= cmd_wr + PW'(1);
            if (issue)    cmd_rd <= cmd_rd + PW'(1);
            if (capture)  res_wr <= res_wr + PW'(1);
            if (res_pop)  res_rd <= res_rd + PW'(1);
            if (issue && !capture)      inflight <= inflight + PW'(1);
            else if (!issue && capture) inflight <= inflight - PW'(1);
            done_count <= done_count + 32'(capture);
            flags      <= (flags & ~flag_clr) | flag_set;
        end
    end

    // Storage needs no reset: empty FIFOs mask their contents at every output.
    always_ff @(posedge clk_clk) begin
        if (cmd_push) begin
            cmd_a[cmd_wr[AW-1:0]]  <= num1_q;
            cmd_b[cmd_wr[AW-1:0]]  <= num2_q;
            cmd_op[cmd_wr[AW-1:0]] <= bus.avs_writedata[OP_W-1:0];
        end
        if (capture) res_mem[res_wr[AW-1:0]] <= bus.result_export;
    end
endmodule

// File: tb/tb_posit_op_bridge.sv
// Randomised bench for posit_op_bridge: queue-level reference model of the
// bridge plus a behavioural posit unit with configurable latency.
module tb_posit_op_bridge;
    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
    } cmd_t;
    typedef struct {
        logic [31:0] val;
        int          due;
    } pend_t;

    logic clk_clk = 1'b0;
    logic reset_reset_n = 1'b0;
    posit_op_bridge_if #(.WIDTH(32), .OP_W(2)) bus ();

    posit_op_bridge #(.WIDTH(32), .OP_W(2), .DEPTH(DEPTH)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .bus           (bus)
    );

    always #5 clk_clk = ~clk_clk;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int lat = 1;
    bit g_rdy = 1'b1;
    logic [31:0] last_rd;

    cmd_t        m_cmd[$];
    logic [31:0] m_infl[$];
    logic [31:0] m_res[$];
    pend_t       pend[$];
    logic [31:0] m_num1, m_num2, m_count;
    logic [2:0]  m_flags;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural unit: posit 1+1=2 for the directed case, integer proxies otherwise.
    function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        case (op)
            2'd0:    unit_fn = (a == 32'h4000_0000 && b == 32'h4000_0000) ? 32'h4800_0000 : a + b;
            2'd1:    unit_fn = a - b;
            2'd2:    unit_fn = a ^ b;
            default: unit_fn = {a[15:0], b[15:0]};
        endcase
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'd0;
        s[0]    = (m_cmd.size() == DEPTH);
        s[1]    = (m_cmd.size() == 0);
        s[2]    = (m_res.size() == 0);
        s[3]    = (m_infl.size() != 0);
        s[6:4]  = m_flags;
        s[15:8] = 8'(m_res.size());
        return s;
    endfunction

    task automatic model_clear();
        m_cmd.delete(); m_infl.delete(); m_res.delete(); pend.delete();
        m_num1 = '0; m_num2 = '0; m_count = '0; m_flags = '0;
    endtask

    task automatic step(input bit wr, input bit rd, input logic [2:0] addr,
                        input logic [31:0] wdata, input bit spur_pulse);
        bit m_valid, m_cap;
        logic [31:0] exp_rd;
        logic [2:0] set_f, clr_f;
        cmd_t c;
        bus.avs_write = wr;
        bus.avs_read = rd;
        bus.avs_address = addr;
        bus.avs_writedata = wdata;
        bus.req_ready = g_rdy;
        if (spur_pulse) begin
            bus.result_valid = 1'b1;
            bus.result_export = $urandom;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.result_valid = 1'b1;
            bus.result_export = pend[0].val;
            void'(pend.pop_front());
        end else begin
            bus.result_valid = 1'b0;
            bus.result_export = '0;
        end
        #1;
        m_valid = (m_cmd.size() > 0) && (m_infl.size() + m_res.size() < DEPTH);
        check("req_valid", bus.req_valid, m_valid);
        if (m_valid) begin
            check("num1_export", bus.num1_export, m_cmd[0].a);
            check("num2_export", bus.num2_export, m_cmd[0].b);
            check("op_export", bus.op_export, m_cmd[0].op);
        end
        if (bus.req_valid && g_rdy)
            pend.push_back('{unit_fn(bus.num1_export, bus.num2_export, bus.op_export), cyc + lat});
        exp_rd = '0; set_f = '0; clr_f = '0;
        if (rd) begin
            case (addr)
                3'd0: exp_rd = m_num1;
                3'd1: exp_rd = m_num2;
                3'd3: if (m_res.size() == 0) set_f[1] = 1'b1; else exp_rd = m_res[0];
                3'd4: exp_rd = model_status();
                3'd5: exp_rd = m_count;
                default: exp_rd = '0;
            endcase
        end
        m_cap = bus.result_valid && (m_infl.size() > 0);
        if (bus.result_valid && m_infl.size() == 0) set_f[2] = 1'b1;
        if (rd && addr == 3'd3 && m_res.size() > 0) void'(m_res.pop_front());
        if (m_cap) begin
            m_res.push_back(m_infl.pop_front());
            m_count++;
        end
        if (m_valid && g_rdy) begin
            c = m_cmd.pop_front();
            m_infl.push_back(unit_fn(c.a, c.b, c.op));
        end
        if (wr) begin
            case (addr)
                3'd0: m_num1 = wdata;
                3'd1: m_num2 = wdata;
                3'd2: if (m_cmd.size() < DEPTH) m_cmd.push_back('{m_num1, m_num2, wdata[1:0]});
                      else set_f[0] = 1'b1;
                3'd4: clr_f = wdata[6:4];
                default: ;
            endcase
        end
        m_flags = (m_flags & ~clr_f) | set_f;
        @(posedge clk_clk);
        #1;
        if (rd) begin
            last_rd = bus.avs_readdata;
            check($sformatf("readdata@%0d", addr), last_rd, exp_rd);
        end
        @(negedge clk_clk);
        cyc++;
    endtask

    task automatic do_wr(input logic [2:0] addr, input logic [31:0] d); step(1'b1, 1'b0, addr, d, 1'b0); endtask
    task automatic do_rd(input logic [2:0] addr); step(1'b0, 1'b1, addr, '0, 1'b0); endtask
    task automatic do_idle(input int n); for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, '0, 1'b0); endtask
    task automatic do_spur(); step(1'b0, 1'b0, 3'd0, '0, 1'b1); endtask

    task automatic do_reset();
        bus.avs_write = 1'b0; bus.avs_read = 1'b0; bus.avs_address = '0;
        bus.avs_writedata = '0; bus.result_valid = 1'b0; bus.result_export = '0;
        bus.req_ready = 1'b0;
        reset_reset_n = 1'b0;
        model_clear();
        @(posedge clk_clk);
        #1;
        check("rst_readdata", bus.avs_readdata, 32'd0);
        check("rst_req_valid", bus.req_valid, 1'b0);
        check("rst_num1", bus.num1_export, 32'd0);
        check("rst_num2", bus.num2_export, 32'd0);
        check("rst_op", bus.op_export, 2'd0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        cyc++;
    endtask

    task automatic drain();
        g_rdy = 1'b1;
        for (int i = 0; i < 300 && (m_cmd.size() + m_infl.size() + m_res.size()) > 0; i++)
            do_rd(3'd3);
        check("drain_done", m_cmd.size() + m_infl.size() + m_res.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.avs_write = 1'b0; bus.avs_read = 1'b0; bus.avs_address = '0;
        bus.avs_writedata = '0; bus.req_ready = 1'b0;
        bus.result_valid = 1'b0; bus.result_export = '0;
        repeat (2) @(negedge clk_clk);

        // T1: single 1+1 operation
        do_reset();
        g_rdy = 1'b1; lat = 3;
        do_wr(3'd0, 32'h4000_0000);
        do_wr(3'd1, 32'h4000_0000);
        do_wr(3'd2, 32'd0);
        do_idle(8);
        do_rd(3'd3); check("t1_result", last_rd, 32'h4800_0000);
        do_rd(3'd5); check("t1_count", last_rd, 32'd1);
        do_rd(3'd4); check("t1_busy", last_rd[3], 1'b0); check("t1_res_empty", last_rd[2], 1'b1);

        // T2: overflow with unit stalled
        g_rdy = 1'b0; lat = 2;
        do_wr(3'd0, $urandom);
        do_wr(3'd1, $urandom);
        for (int i = 0; i < 9; i++) do_wr(3'd2, 32'(i));
        check("t2_req_valid", bus.req_valid, 1'b1);
        do_idle(3);
        do_rd(3'd4); check("t2_cmd_full", last_rd[0], 1'b1); check("t2_ovf", last_rd[4], 1'b1);
        do_wr(3'd4, 32'h10);
        do_rd(3'd4); check("t2_ovf_clr", last_rd[4], 1'b0);
        drain();

        // T3: credit limit
        do_reset();
        g_rdy = 1'b1; lat = 1;
        for (int i = 0; i < 8; i++) begin
            do_wr(3'd0, $urandom);
            do_wr(3'd2, 32'($urandom_range(0, 3)));
        end
        do_idle(6);
        do_wr(3'd2, 32'd1);
        do_idle(2);
        check("t3_blocked", bus.req_valid, 1'b0);
        do_rd(3'd3);
        check("t3_issue", bus.req_valid, 1'b1);
        drain();

        // T4: underflow and spurious result
        do_reset();
        do_rd(3'd3); check("t4_unf_data", last_rd, 32'd0);
        do_rd(3'd4); check("t4_unf", last_rd[5], 1'b1);
        do_spur();
        do_rd(3'd4); check("t4_spur", last_rd[6], 1'b1);
        do_rd(3'd5); check("t4_count", last_rd, 32'd0);

        // T5: streaming 100 ops
        do_reset();
        g_rdy = 1'b1; lat = 1;
        for (int i = 0; i < 100; i++) begin
            do_wr(3'd0, $urandom);
            do_wr(3'd1, $urandom);
            do_wr(3'd2, 32'($urandom_range(0, 3)));
            do_rd(3'd3);
        end
        drain();
        do_rd(3'd5); check("t5_count", last_rd, 32'd100);

        // T6: reset with work in flight
        do_reset();
        g_rdy = 1'b1; lat = 30;
        for (int i = 0; i < 3; i++) do_wr(3'd2, 32'(i));
        do_idle(3);
        do_rd(3'd4); check("t6_busy", last_rd[3], 1'b1);
        do_reset();
        do_rd(3'd4); check("t6_status", last_rd, 32'h6);
        do_spur();
        do_rd(3'd4); check("t6_spur", last_rd, 32'h46);
        do_rd(3'd5); check("t6_count", last_rd, 32'd0);

        // T7: random mixed traffic
        do_reset();
        for (int i = 0; i < 500; i++) begin
            int r;
            g_rdy = ($urandom_range(0, 3) != 0);
            lat = $urandom_range(1, 4);
            r = $urandom_range(0, 11);
            case (r)
                0, 1:    do_wr(3'd0, $urandom);
                2:       do_wr(3'd1, $urandom);
                3, 4:    do_wr(3'd2, $urandom);
                5, 6:    do_rd(3'd3);
                7:       do_rd(3'd4);
                8:       do_rd(3'd5);
                9:       do_wr(3'd4, $urandom);
                10:      if (m_infl.size() == 0 && pend.size() == 0) do_spur(); else do_rd(3'(6 + $urandom_range(0, 1)));
                default: begin do_wr(3'($urandom_range(6, 7)), $urandom); do_rd(3'd0); end
            endcase
        end
        drain();
        do_rd(3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
